avst_to_axis: RTL and testbench
===============================

# avst_to_axis

Receive-side counterpart of the transmit AXIS-to-AVST stage. Converts an Avalon-ST packet stream from the Ethernet MAC RX into AXI4-Stream for the sensor-bridge packet path:
- empty to tkeep
- byte-lane swap
- error to tuser

A small buffer absorbs the source's ready latency, and an optional framing checker removes malformed packets.

## Interface
Parameters:
- DWIDTH, 512, data width in bits; multiple of 8.
- USER_WIDTH, 1, axis_tuser width.
- ERR_WIDTH, 1, avst_error width.
- READY_LATENCY, 0, cycles from avst_ready change to source honouring it; 0..3.
- DEPTH, 4, buffer entries; must be ≥ READY_LATENCY+2, power of two.
- KEEP_WIDTH (localparam), DWIDTH/8.
- EMPTY_MSB (localparam), $clog2(KEEP_WIDTH).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- avst_valid  in  1  beat valid.
- avst_start  in  1  first beat of packet.
- avst_end  in  1  last beat of packet.
- avst_data  in  DWIDTH  data; first symbol in MSBs.
- avst_empty  in  EMPTY_MSB  unused bytes on end beat.
- avst_error  in  ERR_WIDTH  packet error; meaningful on end beat.
- avst_ready  out  1  sink can accept.
- axis_tvalid  out  1  beat valid.
- axis_tdata  out  DWIDTH  byte-swapped data.
- axis_tlast  out  1  last beat.
- axis_tuser  out  USER_WIDTH  bit 0 = error; others 0.
- axis_tkeep  out  KEEP_WIDTH  byte enables.
- axis_tready  in  1  downstream ready.
- frame_err  out  1  one-cycle pulse per framing violation.
- overflow  out  1  one-cycle pulse when a beat arrives with buffer full.

## Operation
- A beat is captured whenever avst_valid=1. avst_valid is not qualified by avst_ready, because the source honours avst_ready READY_LATENCY cycles late.
- avst_ready = 1 when (DEPTH − count) > READY_LATENCY + 1. It is driven from registered count, with no combinational input.
- Capture with buffer full: beat discarded, overflow pulses, state unchanged.
- Data: axis_tdata byte j = avst_data byte (KEEP_WIDTH−1−j).
- Keep:
  - Non-end beat: all ones.
  - End beat: all-ones >> avst_empty, with invalid lanes at the high end.
- tlast = avst_end. tuser[0] = |avst_error on end beat, 0 otherwise.
- Framing FSM, applied at capture:
  - IDLE, start=1, end=0: write beat, go to IN_PKT.
  - IDLE, start=1, end=1: write single-beat packet, stay IDLE.
  - IDLE, start=0: discard beat, frame_err, go to DROP (or stay IDLE if end=1).
  - IN_PKT, start=0: write beat; end=1 returns to IDLE.
  - IN_PKT, start=1: write beat with tlast=1, tuser[0]=1, tkeep all ones, closing the open packet; frame_err; go to DROP, or IDLE if end=1.
  - DROP: discard beats until end=1, then return to IDLE. A start in DROP behaves as in IDLE.
- The FSM advances only on written or discarded beats. Overflowed beats do not advance it.
- Buffer output follows AXIS rules: tvalid stays high and payload stays stable until tready.

## Timing
- Latency: beat captured in cycle N appears on axis_tvalid in cycle N+1 when the buffer is empty.
- Throughput: 1 beat/cycle when axis_tready=1.
- Simultaneous push and pop at full: the push is still an overflow, because count is sampled before the pop.
- Reset values:
  - avst_ready=0 during rst, 1 the cycle after.
  - axis_tvalid=0, frame_err=0, overflow=0; FSM=IDLE; count=0.
  - axis_tdata, axis_tkeep, axis_tlast and axis_tuser are don't-care while tvalid=0.
- Reset mid-packet: buffer flushed, partial packet lost without a tlast. The next beat must carry start=1.

## Configuration
- AVST_TO_AXIS_FRAME_CHECK_EN defined: framing FSM and frame_err as above.
- Undefined: every captured beat is written verbatim with tlast=avst_end, avst_start is ignored, and frame_err is tied 0.

## Structure
- axis_pkg:
  - byte-swap function, shared with the TX converter.
  - empty-to-keep function.
  - framing-state enum (IDLE, IN_PKT, DROP).
- Sub-module avst_skid_fifo: register-based sync FIFO of width DWIDTH+KEEP_WIDTH+2, depth DEPTH. Ports: count, push, pop, full, empty.

## Test plan
- RL=0, DWIDTH=512, 3-beat packet, empty=6 on end → 3 AXIS beats; last tkeep=0x03FF_FFFF_FFFF_FFFF; byte 0 of tdata = avst_data[511:504].
- Error on end beat (avst_error=1) → tlast beat tuser[0]=1; earlier beats tuser=0.
- Beat with start=0 after reset (macro on) → no AXIS output, frame_err pulse, discard until end. The following start packet passes intact.
- start during open packet (macro on) → extra beat with tlast=1, tuser[0]=1, and frame_err. The new packet is dropped through its end.
- READY_LATENCY=2, DEPTH=4, axis_tready=0 while source streams → avst_ready falls at count=1, zero overflow pulses, all beats delivered in order after release.
- Source ignores avst_ready with buffer full → overflow pulse per excess beat, FSM state unchanged.

Source files
------------

// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared AVST/AXIS lane helpers and framing-state type
package axis_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } frame_state_t;

  // Avalon carries the first symbol in the MSBs; AXIS carries it in byte 0.
  function automatic int swap_lane(input int lane, input int nbytes);
    return nbytes - 1 - lane;
  endfunction

  // Lane j of (all-ones >> empty); invalid lanes land at the high end.
  function automatic logic keep_lane(input int lane, input int empty, input int nbytes,
                                     input logic last);
    return !last || (lane < (nbytes - empty));
  endfunction

endpackage

// File: rtl/avst_skid_fifo.sv
// rtl/avst_skid_fifo.sv - register-based sync FIFO absorbing the source ready latency
module avst_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/avst_to_axis.sv
// rtl/avst_to_axis.sv - Avalon-ST RX to AXI4-Stream converter with skid buffer.
// Define AVST_TO_AXIS_FRAME_CHECK_EN to enable the framing checker and frame_err.
module avst_to_axis
  import axis_pkg::*;
#(
  parameter int DWIDTH        = 512,
  parameter int USER_WIDTH    = 1,
  parameter int ERR_WIDTH     = 1,
  parameter int READY_LATENCY = 0,
  parameter int DEPTH         = 4,
  localparam int KEEP_WIDTH   = DWIDTH / 8,
  localparam int EMPTY_MSB    = $clog2(KEEP_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  avst_valid,
  input  logic                  avst_start,
  input  logic                  avst_end,
  input  logic [DWIDTH-1:0]     avst_data,
  input  logic [EMPTY_MSB-1:0]  avst_empty,
  input  logic [ERR_WIDTH-1:0]  avst_error,
  output logic                  avst_ready,
  output logic                  axis_tvalid,
  output logic [DWIDTH-1:0]     axis_tdata,
  output logic                  axis_tlast,
  output logic [USER_WIDTH-1:0] axis_tuser,
  output logic [KEEP_WIDTH-1:0] axis_tkeep,
  input  logic                  axis_tready,
  output logic                  frame_err,
  output logic                  overflow
);
  localparam int FW = DWIDTH + KEEP_WIDTH + 2;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] READY_THRESH = CW'(DEPTH - READY_LATENCY - 1);

  logic [DWIDTH-1:0]     w_swap;
  logic [KEEP_WIDTH-1:0] w_keep;
  logic [KEEP_WIDTH-1:0] w_keep_sel;
  logic                  w_last;
  logic                  w_err;
  logic                  w_write;
  logic                  w_ferr;
  logic                  w_capture;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic [CW-1:0]         w_count;
  logic [FW-1:0]         w_dout;
  logic                  r_rdy_en;
  logic                  r_ovf;
  logic                  r_ferr;

  for (genvar j = 0; j < KEEP_WIDTH; j++) begin : g_lane
    assign w_swap[8*j +: 8] = avst_data[8*swap_lane(j, KEEP_WIDTH) +: 8];
    assign w_keep[j]        = keep_lane(j, int'(avst_empty), KEEP_WIDTH, avst_end);
  end

  // The source may keep sending after ready drops, so valid alone means capture.
  assign w_capture = avst_valid && !w_full;

`ifdef AVST_TO_AXIS_FRAME_CHECK_EN
  frame_state_t r_state;
  frame_state_t w_state_nxt;

  always_comb begin
    w_write     = 1'b0;
    w_ferr      = 1'b0;
    w_last      = avst_end;
    w_err       = avst_end && (|avst_error);
    w_keep_sel  = w_keep;
    w_state_nxt = r_state;
    if (w_capture) begin
      if (r_state == ST_IN_PKT) begin
        w_write = 1'b1;
        if (avst_start) begin
          // A new start closes the open packet as an errored full beat.
          w_last      = 1'b1;
          w_err       = 1'b1;
          w_keep_sel  = '1;
          w_ferr      = 1'b1;
          w_state_nxt = avst_end ? ST_IDLE : ST_DROP;
        end else if (avst_end) begin
          w_state_nxt = ST_IDLE;
        end
      end else if (avst_start) begin
        w_write     = 1'b1;
        w_state_nxt = avst_end ? ST_IDLE : ST_IN_PKT;
      end else begin
        w_ferr      = (r_state == ST_IDLE);
        w_state_nxt = avst_end ? ST_IDLE : ST_DROP;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end
`else
  logic w_unused_start;
  assign w_unused_start = avst_start;
  assign w_write        = w_capture;
  assign w_ferr         = 1'b0;
  assign w_last         = avst_end;
  assign w_err          = avst_end && (|avst_error);
  assign w_keep_sel     = w_keep;
`endif

  avst_skid_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_write),
    .din   ({w_last, w_err, w_keep_sel, w_swap}),
    .pop   (w_pop),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_pop       = axis_tvalid && axis_tready;
  assign axis_tvalid = !w_empty;
  assign axis_tdata  = w_dout[DWIDTH-1:0];
  assign axis_tkeep  = w_dout[DWIDTH +: KEEP_WIDTH];
  assign axis_tlast  = w_dout[FW-1];

  always_comb begin
    axis_tuser    = '0;
    axis_tuser[0] = w_dout[FW-2];
  end

  assign avst_ready = r_rdy_en && (w_count < READY_THRESH);
  assign overflow   = r_ovf;
  assign frame_err  = r_ferr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdy_en <= 1'b0;
      r_ovf    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      r_ovf    <= avst_valid && w_full;
      r_ferr   <= w_ferr;
    end
  end

endmodule

// File: tb/tb_avst_to_axis.sv
// tb/tb_avst_to_axis.sv - scoreboard bench for avst_to_axis (DWIDTH=512, READY_LATENCY=2, DEPTH=4)
module tb_avst_to_axis;
  localparam int DW    = 512;
  localparam int KW    = 64;
  localparam int RL    = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          avst_valid = 1'b0;
  logic          avst_start = 1'b0;
  logic          avst_end = 1'b0;
  logic [DW-1:0] avst_data = '0;
  logic [5:0]    avst_empty = '0;
  logic [0:0]    avst_error = '0;
  logic          avst_ready;
  logic          axis_tvalid;
  logic [DW-1:0] axis_tdata;
  logic          axis_tlast;
  logic [0:0]    axis_tuser;
  logic [KW-1:0] axis_tkeep;
  logic          axis_tready = 1'b1;
  logic          frame_err;
  logic          overflow;

  beat_t exp_q[$];
  int    m_count = 0;
  int    m_state = 0;
  int    exp_ferr = 0, got_ferr = 0;
  int    exp_ovf = 0, got_ovf = 0;
  int    n_checks = 0, n_pass = 0;
  logic [1:0] rdy_hist = 2'b00;

  avst_to_axis #(
    .DWIDTH(DW), .USER_WIDTH(1), .ERR_WIDTH(1), .READY_LATENCY(RL), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .avst_valid(avst_valid), .avst_start(avst_start), .avst_end(avst_end),
    .avst_data(avst_data), .avst_empty(avst_empty), .avst_error(avst_error),
    .avst_ready(avst_ready),
    .axis_tvalid(axis_tvalid), .axis_tdata(axis_tdata), .axis_tlast(axis_tlast),
    .axis_tuser(axis_tuser), .axis_tkeep(axis_tkeep), .axis_tready(axis_tready),
    .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] swap_bytes(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < KW; i++) r[8*i +: 8] = d[DW-1-8*i -: 8];
    return r;
  endfunction

  // Reference model: predicts written beats, overflow and frame errors at each capture edge.
  initial begin
    beat_t b;
    logic  pop, push, wr;
    logic [KW-1:0] all_ones;
    all_ones = '1;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_count = 0;
        m_state = 0;
      end else begin
        pop  = (m_count > 0) && axis_tready;
        push = 1'b0;
        if (avst_valid) begin
          if (m_count == DEPTH) begin
            exp_ovf++;
          end else begin
            b.data = swap_bytes(avst_data);
            b.keep = avst_end ? (all_ones >> avst_empty) : all_ones;
            b.last = avst_end;
            b.user = avst_end & avst_error[0];
`ifdef AVST_TO_AXIS_FRAME_CHECK_EN
            wr = 1'b0;
            if (m_state == 1) begin
              wr = 1'b1;
              if (avst_start) begin
                b.last = 1'b1; b.user = 1'b1; b.keep = all_ones;
                exp_ferr++;
                m_state = avst_end ? 0 : 2;
              end else if (avst_end) begin
                m_state = 0;
              end
            end else if (avst_start) begin
              wr = 1'b1;
              m_state = avst_end ? 0 : 1;
            end else begin
              if (m_state == 0) exp_ferr++;
              m_state = avst_end ? 0 : 2;
            end
`else
            wr = 1'b1;
`endif
            if (wr) begin
              exp_q.push_back(b);
              push = 1'b1;
            end
          end
        end
        m_count = m_count + int'(push) - int'(pop);
      end
    end
  end

  // Output monitor and pulse counters.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      rdy_hist = {rdy_hist[0], avst_ready};
      if (!rst) begin
        if (frame_err) got_ferr++;
        if (overflow)  got_ovf++;
        if (axis_tvalid && axis_tready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_beat: got tdata=%h tlast=%b, required no beat", axis_tdata, axis_tlast);
          end else begin
            e = exp_q.pop_front();
            if (axis_tdata !== e.data || axis_tkeep !== e.keep || axis_tlast !== e.last || axis_tuser !== e.user)
              $display("FAIL beat: got keep=%h last=%b user=%b data=%h, required keep=%h last=%b user=%b data=%h",
                       axis_tkeep, axis_tlast, axis_tuser, axis_tdata, e.keep, e.last, e.user, e.data);
            else
              n_pass++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic beat(input logic s, input logic e, input logic [5:0] emp, input logic er);
    avst_valid = 1'b1; avst_start = s; avst_end = e; avst_empty = emp; avst_error = er;
    avst_data  = {16{$urandom()}};
    @(posedge clk); #1;
    avst_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || m_count != 0) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    repeat (3) begin @(posedge clk); #1; end
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
    else n_pass++;
    n_checks++;
    if (got_ferr != exp_ferr) $display("FAIL %s_frame_err: got %0d pulses, required %0d", name, got_ferr, exp_ferr);
    else n_pass++;
    n_checks++;
    if (got_ovf != exp_ovf) $display("FAIL %s_overflow: got %0d pulses, required %0d", name, got_ovf, exp_ovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (avst_ready !== 1'b0)  $display("FAIL rst_ready: got %b, required 0", avst_ready);  else n_pass++;
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b, required 0", axis_tvalid); else n_pass++;
    n_checks++; if (frame_err !== 1'b0)   $display("FAIL rst_frame_err: got %b, required 0", frame_err); else n_pass++;
    n_checks++; if (overflow !== 1'b0)    $display("FAIL rst_overflow: got %b, required 0", overflow);   else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (avst_ready !== 1'b1)  $display("FAIL post_rst_ready: got %b, required 1", avst_ready); else n_pass++;
  endtask

  task automatic test_basic();
    axis_tready = 1'b1;
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    n_checks++; if (axis_tvalid !== 1'b1) $display("FAIL latency: got tvalid=%b, required 1", axis_tvalid); else n_pass++;
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd6, 1'b0);
    drain("basic");
  endtask

  task automatic test_error();
    beat(1'b1, 1'b0, 6'd0, 1'b1);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd17, 1'b1);
    beat(1'b1, 1'b1, 6'd63, 1'b1);
    beat(1'b1, 1'b1, 6'd0, 1'b0);
    drain("error");
  endtask

`ifdef AVST_TO_AXIS_FRAME_CHECK_EN
  task automatic test_no_start();
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd4, 1'b0);
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd3, 1'b0);
    drain("no_start");
  endtask

  task automatic test_start_in_pkt();
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b1, 1'b0, 6'd9, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd2, 1'b0);
    beat(1'b1, 1'b1, 6'd5, 1'b0);
    drain("start_in_pkt");
  endtask
`else
  task automatic test_no_framing();
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    beat(1'b1, 1'b1, 6'd8, 1'b1);
    beat(1'b0, 1'b1, 6'd1, 1'b0);
    drain("no_framing");
  endtask
`endif

  task automatic test_ready_latency();
    int sent = 0;
    logic exp_rdy;
    axis_tready = 1'b0;
    for (int cyc = 0; cyc < 80 && sent < 6; cyc++) begin
      if (cyc == 12) axis_tready = 1'b1;
      exp_rdy = (DEPTH - m_count) > (RL + 1);
      n_checks++;
      if (avst_ready !== exp_rdy) $display("FAIL rl_ready_c%0d: got %b, required %b", cyc, avst_ready, exp_rdy);
      else n_pass++;
      if (rdy_hist[1]) begin
        avst_valid = 1'b1; avst_start = (sent == 0); avst_end = (sent == 5);
        avst_empty = (sent == 5) ? 6'd10 : 6'd0; avst_error = 1'b0;
        avst_data  = {16{$urandom()}};
        sent++;
      end else begin
        avst_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    avst_valid = 1'b0;
    n_checks++; if (sent != 6) $display("FAIL rl_sent: got %0d beats, required 6", sent); else n_pass++;
    drain("ready_latency");
  endtask

  task automatic test_overflow();
    axis_tready = 1'b0;
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd0, 1'b0);
    axis_tready = 1'b1;
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b1, 6'd2, 1'b1);
    drain("overflow");
  endtask

  task automatic test_reset_mid();
    axis_tready = 1'b0;
    beat(1'b1, 1'b0, 6'd0, 1'b0);
    beat(1'b0, 1'b0, 6'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (axis_tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b, required 0", axis_tvalid); else n_pass++;
    axis_tready = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, 1'b1, 6'd0, 1'b0);
    beat(1'b1, 1'b1, 6'd12, 1'b0);
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
`ifdef AVST_TO_AXIS_FRAME_CHECK_EN
    test_no_start();
    test_start_in_pkt();
`else
    test_no_framing();
`endif
    test_ready_latency();
    test_overflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
